// File: rtl/oled_text_renderer_pkg.sv
// Shared definitions for the OLED text renderer: FSM states, panel/glyph geometry
// and the reset contents of the message buffer.
package oled_text_renderer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StUpdate
    } state_t;

    localparam int unsigned DispW  = 96;
    localparam int unsigned DispH  = 64;
    localparam int unsigned CharW  = 6;
    localparam int unsigned GlyphH = 7;

    // Reset message "HELLO"; slots past the fifth reset to the blank code.
    function automatic logic [6:0] hello_code(input int i);
        case (i)
            0:       hello_code = 7'd72;
            1:       hello_code = 7'd69;
            2:       hello_code = 7'd76;
            3:       hello_code = 7'd76;
            4:       hello_code = 7'd79;
            default: hello_code = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/oled_text_renderer_msg_buffer.sv
// Message register file: one write port, asynchronous read, resets to "HELLO".
// Writes to addresses at or beyond MSG_LEN match no entry and are dropped.
module oled_text_renderer_msg_buffer
    import oled_text_renderer_pkg::*;
#(
    parameter int unsigned MSG_LEN = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] wr_addr,
    input  logic [6:0] wr_data,
    input  logic [2:0] rd_addr,
    output logic [6:0] rd_data
);

    logic [6:0] msg_q [MSG_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MSG_LEN); i++) begin
                msg_q[i] <= hello_code(i);
            end
        end else if (we) begin
            for (int i = 0; i < int'(MSG_LEN); i++) begin
                if (wr_addr == 3'(i)) begin
                    msg_q[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(MSG_LEN); i++) begin
            if (rd_addr == 3'(i)) begin
                rd_data = msg_q[i];
            end
        end
    end

endmodule

// File: rtl/oled_text_renderer.sv
// Raster pixel generator: walks the panel per frame, drives font ROM lookups and
// streams one bit per pixel over valid/ready, with a wrapping horizontal scroll.
module oled_text_renderer
    import oled_text_renderer_pkg::*;
#(
    parameter int unsigned DISP_W          = DispW,
    parameter int unsigned DISP_H          = DispH,
    parameter int unsigned MSG_LEN         = 5,
    parameter int unsigned CHAR_W          = CharW,
    parameter int unsigned Y_OFF           = 28,
    parameter int unsigned FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       scroll_en,
    input  logic       msg_we,
    input  logic [2:0] msg_addr,
    input  logic [6:0] msg_data,
    output logic [6:0] font_char,
    output logic [2:0] font_row,
    input  logic [4:0] font_pixels,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_on,
    output logic       pix_last,
    output logic       busy
);

    localparam int unsigned XW = $clog2(DISP_W);
    localparam int unsigned YW = $clog2(DISP_H);
    localparam int unsigned FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    state_t        state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [2:0]    cidx_q, ccol_q;
    logic [2:0]    scroll_char_q, scroll_col_q;
    logic [FW-1:0] frame_cnt_q;

    logic [6:0]    code;
    logic [YW-1:0] yrel;
    logic [4:0]    shifted;
    logic          in_band, pixel, line_end, frame_end;
    logic [2:0]    cidx_step, ccol_step, scroll_char_step, scroll_col_step;

    oled_text_renderer_msg_buffer #(
        .MSG_LEN (MSG_LEN)
    ) u_msg_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (msg_we),
        .wr_addr (msg_addr),
        .wr_data (msg_data),
        .rd_addr (cidx_q),
        .rd_data (code)
    );

    // ROM address is only presented while streaming so it idles at zero.
    assign yrel      = y_q - YW'(Y_OFF);
    assign font_char = (state_q == StStream) ? code : '0;
    assign font_row  = (state_q == StStream) ? yrel[2:0] : '0;

    assign in_band   = (y_q >= YW'(Y_OFF)) && (y_q <= YW'(Y_OFF + GlyphH - 1));
    assign shifted   = font_pixels << ccol_q;
    assign pixel     = in_band && (ccol_q <= 3'd4) && (code != 7'd0) && shifted[4];
    assign line_end  = (x_q == XW'(DISP_W - 1));
    assign frame_end = line_end && (y_q == YW'(DISP_H - 1));

    always_comb begin
        ccol_step = ccol_q + 3'd1;
        cidx_step = cidx_q;
        if (ccol_q == 3'(CHAR_W - 1)) begin
            ccol_step = '0;
            cidx_step = (cidx_q == 3'(MSG_LEN - 1)) ? '0 : cidx_q + 3'd1;
        end
    end

    always_comb begin
        scroll_col_step  = scroll_col_q + 3'd1;
        scroll_char_step = scroll_char_q;
        if (scroll_col_q == 3'(CHAR_W - 1)) begin
            scroll_col_step  = '0;
            scroll_char_step = (scroll_char_q == 3'(MSG_LEN - 1)) ? '0 : scroll_char_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            cidx_q        <= '0;
            ccol_q        <= '0;
            scroll_char_q <= '0;
            scroll_col_q  <= '0;
            frame_cnt_q   <= '0;
            pix_valid     <= 1'b0;
            pix_on        <= 1'b0;
            pix_last      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        state_q <= StStream;
                        busy    <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                        cidx_q  <= scroll_char_q;
                        ccol_q  <= scroll_col_q;
                    end
                end
                StStream: begin
                    if (pix_valid && pix_ready && pix_last) begin
                        pix_valid <= 1'b0;
                        pix_on    <= 1'b0;
                        pix_last  <= 1'b0;
                        state_q   <= StUpdate;
                    end else if (!pix_valid || pix_ready) begin
                        pix_valid <= 1'b1;
                        pix_on    <= pixel;
                        pix_last  <= frame_end;
                        // Every line restarts from the scroll position; no divider needed.
                        if (line_end) begin
                            x_q    <= '0;
                            y_q    <= y_q + YW'(1);
                            cidx_q <= scroll_char_q;
                            ccol_q <= scroll_col_q;
                        end else begin
                            x_q    <= x_q + XW'(1);
                            cidx_q <= cidx_step;
                            ccol_q <= ccol_step;
                        end
                    end
                end
                StUpdate: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    if (frame_cnt_q == FW'(FRAMES_PER_STEP - 1)) begin
                        frame_cnt_q <= '0;
                        if (scroll_en) begin
                            scroll_char_q <= scroll_char_step;
                            scroll_col_q  <= scroll_col_step;
                        end
                    end else begin
                        frame_cnt_q <= frame_cnt_q + FW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_text_renderer.sv
// Directed bench: a full-size instance checks frame geometry and backpressure, a
// reduced-size instance exercises scroll wrap, message writes and mid-frame reset.
module tb_oled_text_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, scroll_en, msg_we;
    logic [2:0] msg_addr;
    logic [6:0] msg_data;

    logic       fs_a, rdy_a, pv_a, po_a, pl_a, bz_a;
    logic [6:0] fc_a;
    logic [2:0] fr_a;
    logic [4:0] fp_a;
    logic       fs_b, rdy_b, pv_b, po_b, pl_b, bz_b;
    logic [6:0] fc_b;
    logic [2:0] fr_b;
    logic [4:0] fp_b;

    int errs   = 0;
    int checks = 0;

    logic [6:0] mm [5];
    int         sp [2];
    int         fcnt [2];
    int         r28 [96];

    function automatic logic [4:0] rom(input logic [6:0] c, input logic [2:0] r);
        case (c)
            7'd72:   rom = (r == 3) ? 5'b11111 : 5'b10001;
            7'd69:   rom = (r == 0 || r == 6) ? 5'b11111 : (r == 3) ? 5'b11110 : 5'b10000;
            7'd76:   rom = (r == 6) ? 5'b11111 : 5'b10000;
            7'd79:   rom = (r == 0 || r == 6) ? 5'b01110 : 5'b10001;
            default: rom = 5'b11111;
        endcase
    endfunction

    assign fp_a = rom(fc_a, fr_a);
    assign fp_b = rom(fc_b, fr_b);

    oled_text_renderer dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .scroll_en(scroll_en),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
        .font_char(fc_a), .font_row(fr_a), .font_pixels(fp_a),
        .pix_valid(pv_a), .pix_ready(rdy_a), .pix_on(po_a), .pix_last(pl_a), .busy(bz_a)
    );

    oled_text_renderer #(
        .DISP_W(16), .DISP_H(35), .FRAMES_PER_STEP(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .scroll_en(scroll_en),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
        .font_char(fc_b), .font_row(fr_b), .font_pixels(fp_b),
        .pix_valid(pv_b), .pix_ready(rdy_b), .pix_on(po_b), .pix_last(pl_b), .busy(bz_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference pixel: scroll position s shifts the 30-pixel message period.
    function automatic int exp_pix(input int x, input int y, input int s);
        int         pos, ci, cc;
        logic [6:0] c;
        logic [4:0] g;
        pos = (s + x) % 30;
        ci  = pos / 6;
        cc  = pos % 6;
        c   = mm[ci];
        if (y < 28 || y > 34 || cc > 4 || c == 7'd0) return 0;
        g = rom(c, 3'(y - 28));
        return int'(g[4 - cc]);
    endfunction

    task automatic drive_fs(input int sel, input logic v);
        if (sel != 0) fs_b = v;
        else fs_a = v;
    endtask

    task automatic drive_rdy(input int sel, input logic v);
        if (sel != 0) rdy_b = v;
        else rdy_a = v;
    endtask

    task automatic reset_model();
        mm[0] = 7'd72; mm[1] = 7'd69; mm[2] = 7'd76; mm[3] = 7'd76; mm[4] = 7'd79;
        sp[0] = 0; sp[1] = 0; fcnt[0] = 0; fcnt[1] = 0;
    endtask

    task automatic run_frame(input int sel, input int bp_pct, input int stop_at,
                             input int wr_at, input bit chk_lat, output int nmis);
        int   w, h, fps, px, py, acc, lastbad, stallbad, cyc, wph;
        bit   done, stopped, stalled, rdy, pv, po, pl, bz, prev_on, prev_last;
        w = (sel != 0) ? 16 : 96;
        h = (sel != 0) ? 35 : 64;
        fps = (sel != 0) ? 2 : 4;
        px = 0; py = 0; acc = 0; lastbad = 0; stallbad = 0; cyc = 0; wph = 0;
        done = 0; stopped = 0; stalled = 0; prev_on = 0; prev_last = 0;
        nmis = 0;
        drive_fs(sel, 1'b1);
        @(negedge clk);
        drive_fs(sel, 1'b0);
        if (chk_lat) begin
            check_eq("latency_n1_valid", int'(sel != 0 ? pv_b : pv_a), 0);
            @(negedge clk);
            check_eq("latency_n2_valid", int'(sel != 0 ? pv_b : pv_a), 1);
        end
        while (!done && !stopped && cyc < w * h * 6 + 50) begin
            pv = (sel != 0) ? pv_b : pv_a;
            po = (sel != 0) ? po_b : po_a;
            pl = (sel != 0) ? pl_b : pl_a;
            if (stalled && (po != prev_on || pl != prev_last || !pv)) stallbad++;
            if (wr_at >= 0 && acc >= wr_at && wph == 0) begin
                msg_we = 1'b1; msg_addr = 3'd1; msg_data = 7'd0; mm[1] = 7'd0; wph = 1;
            end else if (wph == 1) begin
                msg_addr = 3'd6; msg_data = 7'd72; wph = 2;
            end else if (wph == 2) begin
                msg_we = 1'b0; wph = 3;
            end
            rdy = (bp_pct >= 100) ? 1'b1 : ($urandom_range(99) < bp_pct);
            drive_rdy(sel, rdy);
            if (pv && rdy) begin
                if (int'(po) != exp_pix(px, py, sp[sel])) nmis++;
                if (pl != (px == w - 1 && py == h - 1)) lastbad++;
                if (py == 28) r28[px] = int'(po);
                acc++;
                if (pl) done = 1;
                if (px == w - 1) begin
                    px = 0; py++;
                end else begin
                    px++;
                end
                stalled = 0;
            end else begin
                stalled = pv;
            end
            prev_on = po;
            prev_last = pl;
            if (stop_at >= 0 && acc == stop_at) stopped = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        drive_rdy(sel, 1'b1);
        if (stopped) return;
        check_eq("frame_completed", int'(done), 1);
        check_eq("pixel_count", acc, w * h);
        check_eq("pix_last_placement", lastbad, 0);
        check_eq("stall_hold", stallbad, 0);
        check_eq("valid_drop_after_last", int'(sel != 0 ? pv_b : pv_a), 0);
        check_eq("busy_in_update", int'(sel != 0 ? bz_b : bz_a), 1);
        @(negedge clk);
        bz = (sel != 0) ? bz_b : bz_a;
        check_eq("idle_after_update", int'(bz), 0);
        if (fcnt[sel] == fps - 1) begin
            fcnt[sel] = 0;
            if (scroll_en) sp[sel] = (sp[sel] + 1) % 30;
        end else begin
            fcnt[sel]++;
        end
    endtask

    initial begin
        int n, total;
        rst_n = 1'b0; scroll_en = 1'b1; msg_we = 1'b0; msg_addr = '0; msg_data = '0;
        fs_a = 1'b0; fs_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        reset_model();
        #1;
        check_eq("rst_pix_valid", int'(pv_a), 0);
        check_eq("rst_pix_on", int'(po_a), 0);
        check_eq("rst_pix_last", int'(pl_a), 0);
        check_eq("rst_busy", int'(bz_a), 0);
        check_eq("rst_font_char", int'(fc_a), 0);
        check_eq("rst_font_row", int'(fr_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-size panel, ready held high, scroll 0.
        run_frame(0, 100, -1, -1, 1, n);
        check_eq("a_f1_bits", n, 0);
        check_eq("a_f1_r28_x0", r28[0], 1);
        check_eq("a_f1_r28_x1", r28[1], 0);
        check_eq("a_f1_r28_x2", r28[2], 0);
        check_eq("a_f1_r28_x3", r28[3], 0);
        check_eq("a_f1_r28_x4", r28[4], 1);
        check_eq("a_f1_r28_x5", r28[5], 0);

        // Same frame content under random backpressure.
        run_frame(0, 70, -1, -1, 0, n);
        check_eq("a_bp_bits", n, 0);
        check_eq("a_bp_r28_x0", r28[0], 1);
        check_eq("a_bp_r28_x4", r28[4], 1);

        // Reduced panel: two frames per scroll step.
        total = 0;
        for (int f = 1; f <= 3; f++) begin
            run_frame(1, 100, -1, -1, f == 1, n);
            total += n;
        end
        check_eq("b_f123_bits", total, 0);
        check_eq("b_f3_r28_x0", r28[0], 0);
        check_eq("b_f3_r28_x3", r28[3], 1);
        check_eq("b_f3_r28_x4", r28[4], 0);
        check_eq("b_f3_r28_x5", r28[5], 1);

        total = 0;
        for (int f = 4; f <= 60; f++) begin
            run_frame(1, 100, -1, -1, 0, n);
            total += n;
        end
        check_eq("b_scroll_run_bits", total, 0);
        check_eq("b_f60_r28_x0", r28[0], 0);
        check_eq("b_f60_r28_x1", r28[1], 1);

        run_frame(1, 100, -1, -1, 0, n);
        check_eq("b_f61_bits", n, 0);
        check_eq("b_f61_r28_x0", r28[0], 1);
        check_eq("b_f61_r28_x1", r28[1], 0);
        check_eq("b_f61_r28_x4", r28[4], 1);

        // Scrolling disabled: picture must stay put.
        scroll_en = 1'b0;
        total = 0;
        for (int f = 0; f < 8; f++) begin
            run_frame(1, 100, -1, -1, 0, n);
            total += n;
        end
        check_eq("b_noscroll_bits", total, 0);
        check_eq("b_noscroll_r28_x0", r28[0], 1);
        check_eq("b_noscroll_r28_x4", r28[4], 1);

        // Blank msg[1] mid-frame (row 10), plus an out-of-range write.
        run_frame(1, 100, -1, 170, 0, n);
        check_eq("b_msgwr_bits", n, 0);
        check_eq("b_msgwr_r28_x6", r28[6], 0);
        check_eq("b_msgwr_r28_x12", r28[12], 1);
        run_frame(1, 100, -1, -1, 0, n);
        check_eq("b_msgwr2_bits", n, 0);
        check_eq("b_msgwr2_r28_x6", r28[6], 0);
        check_eq("b_msgwr2_r28_x0", r28[0], 1);

        // Move scroll off zero, then reset in the middle of a frame.
        scroll_en = 1'b1;
        run_frame(1, 100, -1, -1, 0, n);
        run_frame(1, 100, -1, -1, 0, n);
        check_eq("b_prereset_bits", n, 0);
        run_frame(1, 100, 300, -1, 0, n);
        check_eq("b_prereset_valid", int'(pv_b), 1);
        rst_n = 1'b0;
        #1;
        check_eq("b_midrst_valid", int'(pv_b), 0);
        check_eq("b_midrst_busy", int'(bz_b), 0);
        check_eq("b_midrst_font_char", int'(fc_b), 0);
        check_eq("b_midrst_pix_on", int'(po_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        run_frame(1, 100, -1, -1, 1, n);
        check_eq("b_postrst_bits", n, 0);
        check_eq("b_postrst_r28_x0", r28[0], 1);
        check_eq("b_postrst_r28_x3", r28[3], 0);
        check_eq("b_postrst_r28_x6", r28[6], 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
